apb_xfer_ctrl: RTL and testbench

// - APB-side transfer sequencer of the AHB2APB bridge; sits between the AHB slave interface FSM and the APB slaves.
// - Accepts one decoded request at a time, drives the APB SETUP/ACCESS phases and one-hot psel, and waits on the selected pready.
// - Times out hung slaves; returns status and read data to the AHB side for hresp/hrdata generation.

---
 rtl/apb_xfer_ctrl_pkg.sv | 19 +
 rtl/apb_wait_timer.sv | 40 ++++
 rtl/apb_xfer_ctrl.sv | 157 +++++++++++++++
 tb/tb_apb_xfer_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_xfer_ctrl_pkg.sv
// Shared bridge widths, APB sequencer state encoding and timer sizing helper.
package apb_xfer_ctrl_pkg;

  localparam int unsigned PADDR_WIDTH    = 32;
  localparam int unsigned APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StDone   = 2'd3
  } apb_state_e;

  // A zero timeout disables the timer but still needs a 1-bit counter.
  function automatic int unsigned tmr_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait cycles and flags the cycle in which the TIMEOUT-th wait occurs.
module apb_wait_timer
  import apb_xfer_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = tmr_width(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  // The current wait cycle is included, so expiry fires when TIMEOUT-1 waits are already counted.
  always_comb begin
    expired_o = (TIMEOUT != 0) && en_i && (cnt_q == CntW'(TIMEOUT - 1));
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_xfer_ctrl.sv
// APB-side transfer sequencer of the AHB2APB bridge: SETUP/ACCESS phasing, slave select,
// wait-state timeout and completion status back to the AHB interface.
module apb_xfer_ctrl
  import apb_xfer_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned SEL_LSB = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                              hclk,
  input  logic                              hreset_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [PADDR_WIDTH-1:0]            req_addr,
  input  logic [APB_DATA_WIDTH-1:0]         req_wdata,
  output logic [NUM_SLV-1:0]                psel,
  output logic                              penable,
  output logic [PADDR_WIDTH-1:0]            paddr,
  output logic                              pwrite,
  output logic [APB_DATA_WIDTH-1:0]         pwdata,
  input  logic [NUM_SLV*APB_DATA_WIDTH-1:0] prdata_x,
  input  logic [NUM_SLV-1:0]                pready_x,
  input  logic [NUM_SLV-1:0]                pslverr_x,
  output logic                              done_valid,
  output logic                              done_err,
  output logic                              done_tmo,
  output logic [APB_DATA_WIDTH-1:0]         done_rdata
);

  apb_state_e                state_q, state_d;
  logic [SEL_W-1:0]          idx_q, idx_d;
  logic [PADDR_WIDTH-1:0]    paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic                      err_q, err_d;
  logic                      tmo_q, tmo_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [SEL_W-1:0]          req_idx;
  logic                      req_hit;
  int unsigned               sel_base;
  logic                      sel_ready;
  logic                      sel_err;
  logic [APB_DATA_WIDTH-1:0] sel_rdata;
  logic                      tmr_expired;

  assign req_idx   = req_addr[SEL_LSB +: SEL_W];
  assign req_hit   = 32'(req_idx) < NUM_SLV;
  assign sel_base  = 32'(idx_q) * APB_DATA_WIDTH;
  assign sel_ready = pready_x[idx_q];
  assign sel_err   = pslverr_x[idx_q];
  assign sel_rdata = prdata_x[sel_base +: APB_DATA_WIDTH];

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (hclk),
    .rst_ni    (hreset_n),
    .clear_i   (state_q != StAccess),
    .en_i      ((state_q == StAccess) && !sel_ready),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          idx_d    = req_idx;
          paddr_d  = req_addr;
          pwdata_d = req_wdata;
          pwrite_d = req_write;
          err_d    = !req_hit;
          tmo_d    = 1'b0;
          rdata_d  = '0;
          state_d  = req_hit ? StSetup : StDone;
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        // pready wins over a timeout landing in the same cycle.
        if (sel_ready) begin
          err_d   = sel_err;
          rdata_d = (!pwrite_q && !sel_err) ? sel_rdata : '0;
          state_d = StDone;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    psel       = '0;
    penable    = 1'b0;
    done_valid = 1'b0;
    done_err   = 1'b0;
    done_tmo   = 1'b0;
    done_rdata = '0;
    unique case (state_q)
      StIdle:  req_ready = 1'b1;
      StSetup: psel[idx_q] = 1'b1;
      StAccess: begin
        psel[idx_q] = 1'b1;
        penable     = 1'b1;
      end
      StDone: begin
        done_valid = 1'b1;
        done_err   = err_q;
        done_tmo   = tmo_q;
        done_rdata = rdata_q;
      end
      default: req_ready = 1'b0;
    endcase
  end

  assign paddr  = paddr_q;
  assign pwrite = pwrite_q;
  assign pwdata = pwdata_q;

endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// Directed bench for apb_xfer_ctrl: cycle vector table plus timeout, decode-miss and reset sequences.
module tb_apb_xfer_ctrl;

  logic         hclk;
  logic         hreset_n;
  logic         req_valid, req_valid3;
  logic         req_write;
  logic [31:0]  req_addr, req_wdata;
  logic [127:0] prdata_x;
  logic [3:0]   pready_x, pslverr_x;

  logic         req_ready, penable, pwrite, done_valid, done_err, done_tmo;
  logic [3:0]   psel;
  logic [31:0]  paddr, pwdata, done_rdata;

  logic         req_ready3, penable3, pwrite3, done_valid3, done_err3, done_tmo3;
  logic [2:0]   psel3;
  logic [31:0]  paddr3, pwdata3, done_rdata3;

  int checks = 0;
  int errors = 0;

  apb_xfer_ctrl #(.NUM_SLV(4), .SEL_W(2), .SEL_LSB(12), .TIMEOUT(16)) u_dut (
    .hclk(hclk), .hreset_n(hreset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .psel(psel),
    .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
    .prdata_x(prdata_x), .pready_x(pready_x), .pslverr_x(pslverr_x),
    .done_valid(done_valid), .done_err(done_err), .done_tmo(done_tmo),
    .done_rdata(done_rdata)
  );

  apb_xfer_ctrl #(.NUM_SLV(3), .SEL_W(2), .SEL_LSB(12), .TIMEOUT(16)) u_dut3 (
    .hclk(hclk), .hreset_n(hreset_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .psel(psel3),
    .penable(penable3), .paddr(paddr3), .pwrite(pwrite3), .pwdata(pwdata3),
    .prdata_x(prdata_x[95:0]), .pready_x(pready_x[2:0]), .pslverr_x(pslverr_x[2:0]),
    .done_valid(done_valid3), .done_err(done_err3), .done_tmo(done_tmo3),
    .done_rdata(done_rdata3)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  pready;
    logic [3:0]  pslverr;
    logic        e_rdy;
    logic [3:0]  e_psel;
    logic        e_pen;
    logic [31:0] e_paddr;
    logic        e_pwr;
    logic [31:0] e_pwdata;
    logic        e_dv;
    logic        e_err;
    logic        e_tmo;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t vrow(
    input logic v, input logic w, input logic [31:0] a, input logic [31:0] wd,
    input logic [3:0] pr, input logic [3:0] se,
    input logic rdy, input logic [3:0] ps, input logic pen, input logic [31:0] pa,
    input logic pw, input logic [31:0] pwd, input logic dv, input logic er,
    input logic tm, input logic [31:0] rd);
    vec_t r;
    r.valid = v; r.write = w; r.addr = a; r.wdata = wd; r.pready = pr; r.pslverr = se;
    r.e_rdy = rdy; r.e_psel = ps; r.e_pen = pen; r.e_paddr = pa; r.e_pwr = pw;
    r.e_pwdata = pwd; r.e_dv = dv; r.e_err = er; r.e_tmo = tm; r.e_rdata = rd;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h want %h", name, row, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = 1'b0;
    req_valid3 = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    pslverr_x  = 4'h0;
  endtask

  int n;

  initial begin
    idle_inputs();
    pready_x = 4'hF;
    prdata_x = {32'h3333_3333, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};
    hreset_n = 1'b0;
    tick();
    tick();
    chk("rst_psel", 0, 32'(psel), 32'h0);
    chk("rst_pen", 0, 32'(penable), 32'h0);
    chk("rst_paddr", 0, paddr, 32'h0);
    chk("rst_dv", 0, 32'(done_valid), 32'h0);
    hreset_n = 1'b1;

    // Write slave1 zero-wait, read slave2 with 3 waits, write slave0 with pslverr.
    vecs.push_back(vrow(1,1,32'h1000,32'hA5A5_5A5A,4'hF,4'h0, 1,4'h0,0,32'h0,   0,32'h0,        0,0,0,32'h0));
    vecs.push_back(vrow(0,0,32'h0,   32'h0,        4'hF,4'h0, 0,4'h2,0,32'h1000,1,32'hA5A5_5A5A,0,0,0,32'h0));
    vecs.push_back(vrow(0,0,32'h0,   32'h0,        4'hF,4'h0, 0,4'h2,1,32'h1000,1,32'hA5A5_5A5A,0,0,0,32'h0));
    vecs.push_back(vrow(0,0,32'h0,   32'h0,        4'hF,4'h0, 0,4'h0,0,32'h1000,1,32'hA5A5_5A5A,1,0,0,32'h0));
    vecs.push_back(vrow(1,0,32'h2004,32'hFFFF_0000,4'hF,4'h0, 1,4'h0,0,32'h1000,1,32'hA5A5_5A5A,0,0,0,32'h0));
    vecs.push_back(vrow(0,0,32'h0,   32'h0,        4'hB,4'h0, 0,4'h4,0,32'h2004,0,32'hFFFF_0000,0,0,0,32'h0));
    vecs.push_back(vrow(0,0,32'h0,   32'h0,        4'hB,4'h0, 0,4'h4,1,32'h2004,0,32'hFFFF_0000,0,0,0,32'h0));
    vecs.push_back(vrow(0,0,32'h0,   32'h0,        4'hB,4'h0, 0,4'h4,1,32'h2004,0,32'hFFFF_0000,0,0,0,32'h0));
    vecs.push_back(vrow(0,0,32'h0,   32'h0,        4'hB,4'h0, 0,4'h4,1,32'h2004,0,32'hFFFF_0000,0,0,0,32'h0));
    vecs.push_back(vrow(0,0,32'h0,   32'h0,        4'hF,4'hB, 0,4'h4,1,32'h2004,0,32'hFFFF_0000,0,0,0,32'h0));
    vecs.push_back(vrow(0,0,32'h0,   32'h0,        4'hF,4'h0, 0,4'h0,0,32'h2004,0,32'hFFFF_0000,1,0,0,32'hDEAD_BEEF));
    vecs.push_back(vrow(1,1,32'h0040,32'h1234_5678,4'hF,4'h0, 1,4'h0,0,32'h2004,0,32'hFFFF_0000,0,0,0,32'h0));
    vecs.push_back(vrow(0,0,32'h0,   32'h0,        4'hF,4'h0, 0,4'h1,0,32'h0040,1,32'h1234_5678,0,0,0,32'h0));
    vecs.push_back(vrow(0,0,32'h0,   32'h0,        4'hF,4'h1, 0,4'h1,1,32'h0040,1,32'h1234_5678,0,0,0,32'h0));
    vecs.push_back(vrow(0,0,32'h0,   32'h0,        4'hF,4'h0, 0,4'h0,0,32'h0040,1,32'h1234_5678,1,1,0,32'h0));
    vecs.push_back(vrow(0,0,32'h0,   32'h0,        4'hF,4'h0, 1,4'h0,0,32'h0040,1,32'h1234_5678,0,0,0,32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      req_valid = vecs[i].valid;
      req_write = vecs[i].write;
      req_addr  = vecs[i].addr;
      req_wdata = vecs[i].wdata;
      pready_x  = vecs[i].pready;
      pslverr_x = vecs[i].pslverr;
      chk("req_ready", i, 32'(req_ready), 32'(vecs[i].e_rdy));
      chk("psel", i, 32'(psel), 32'(vecs[i].e_psel));
      chk("penable", i, 32'(penable), 32'(vecs[i].e_pen));
      chk("paddr", i, paddr, vecs[i].e_paddr);
      chk("pwrite", i, 32'(pwrite), 32'(vecs[i].e_pwr));
      chk("pwdata", i, pwdata, vecs[i].e_pwdata);
      chk("done_valid", i, 32'(done_valid), 32'(vecs[i].e_dv));
      chk("done_err", i, 32'(done_err), 32'(vecs[i].e_err));
      chk("done_tmo", i, 32'(done_tmo), 32'(vecs[i].e_tmo));
      chk("done_rdata", i, done_rdata, vecs[i].e_rdata);
      tick();
    end

    // Timeout: slave3 never ready, expect 16 ACCESS cycles then abort.
    idle_inputs();
    req_valid = 1'b1;
    req_addr  = 32'h3000;
    pready_x  = 4'h7;
    tick();
    req_valid = 1'b0;
    chk("tmo_setup_psel", 100, 32'(psel), 32'h8);
    chk("tmo_setup_pen", 100, 32'(penable), 32'h0);
    tick();
    n = 0;
    while (penable && n < 40) begin
      chk("tmo_paddr", 101, paddr, 32'h3000);
      n++;
      tick();
    end
    chk("tmo_access_cycles", 102, 32'(n), 32'd16);
    chk("tmo_psel", 102, 32'(psel), 32'h0);
    chk("tmo_dv", 102, 32'(done_valid), 32'h1);
    chk("tmo_err", 102, 32'(done_err), 32'h1);
    chk("tmo_tmo", 102, 32'(done_tmo), 32'h1);
    chk("tmo_rdata", 102, done_rdata, 32'h0);
    tick();
    chk("tmo_after_dv", 103, 32'(done_valid), 32'h0);
    chk("tmo_after_rdy", 103, 32'(req_ready), 32'h1);

    // Decode miss on the 3-slave instance.
    pready_x   = 4'hF;
    req_valid3 = 1'b1;
    req_addr   = 32'h3000;
    chk("miss_accept_psel", 200, 32'(psel3), 32'h0);
    tick();
    req_valid3 = 1'b0;
    chk("miss_dv", 201, 32'(done_valid3), 32'h1);
    chk("miss_err", 201, 32'(done_err3), 32'h1);
    chk("miss_tmo", 201, 32'(done_tmo3), 32'h0);
    chk("miss_psel", 201, 32'(psel3), 32'h0);
    chk("miss_pen", 201, 32'(penable3), 32'h0);
    tick();
    chk("miss_after_dv", 202, 32'(done_valid3), 32'h0);
    chk("miss_after_rdy", 202, 32'(req_ready3), 32'h1);

    // Reset during an ACCESS wait, then a clean transfer.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h1008;
    pready_x  = 4'hD;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("rst_mid_pen_before", 300, 32'(penable), 32'h1);
    hreset_n = 1'b0;
    tick();
    hreset_n = 1'b1;
    pready_x = 4'hF;
    chk("rst_mid_psel", 301, 32'(psel), 32'h0);
    chk("rst_mid_pen", 301, 32'(penable), 32'h0);
    chk("rst_mid_paddr", 301, paddr, 32'h0);
    chk("rst_mid_pwdata", 301, pwdata, 32'h0);
    chk("rst_mid_dv", 301, 32'(done_valid), 32'h0);
    chk("rst_mid_rdy", 301, 32'(req_ready), 32'h1);
    tick();
    chk("rst_mid_no_done", 302, 32'(done_valid), 32'h0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h1010;
    req_wdata = 32'hCAFE_F00D;
    tick();
    req_valid = 1'b0;
    chk("post_rst_psel", 303, 32'(psel), 32'h2);
    tick();
    chk("post_rst_pen", 304, 32'(penable), 32'h1);
    tick();
    chk("post_rst_dv", 305, 32'(done_valid), 32'h1);
    chk("post_rst_err", 305, 32'(done_err), 32'h0);
    chk("post_rst_paddr", 305, paddr, 32'h1010);
    chk("post_rst_pwdata", 305, pwdata, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
